// File: rtl/dphy_pkg.sv
// Shared types and helpers for the D-PHY lane receiver and the CSI-2 packet layer above it.
package dphy_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic {
    HUNT    = 1'b0,
    RECEIVE = 1'b1
  } lane_state_t;

  // One rising edge worth of lane bits, in wire order.
  typedef struct packed {
    logic second;
    logic first;
  } bit_pair_t;

  // CSI-2 packet header ECC: six Hamming parity bits over the 24-bit header, top two bits zero.
  function automatic logic [7:0] csi_ecc(input logic [23:0] d);
    logic [7:0] e;
    e    = 8'h00;
    e[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16] ^
           d[20] ^ d[21] ^ d[22] ^ d[23];
    e[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17] ^
           d[20] ^ d[21] ^ d[22] ^ d[23];
    e[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18] ^
           d[20] ^ d[21] ^ d[22];
    e[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19] ^
           d[20] ^ d[21] ^ d[23];
    e[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^
           d[20] ^ d[22] ^ d[23];
    e[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^
           d[21] ^ d[22] ^ d[23];
    return e;
  endfunction

endpackage

// File: rtl/csi_header_ecc.sv
// Combinational CSI-2 header ECC generator for the packet layer; no clock or reset.
module csi_header_ecc
  import dphy_pkg::*;
(
  input  logic [23:0] data,
  output logic [7:0]  ecc
);

  assign ecc = csi_ecc(data);

endmodule

// File: rtl/dphy_ddr_capture.sv
// DDR front end: holds the falling-edge sample and pairs it with the live lane for the rising edge.
module dphy_ddr_capture
  import dphy_pkg::*;
(
  input  logic      clock_p,
  input  logic      reset,
  input  logic      data_p,
  output bit_pair_t o_pair
);

  logic r_neg;

  always_ff @(negedge clock_p) begin
    if (reset) r_neg <= 1'b0;
    else       r_neg <= data_p;
  end

  // The rising-edge sample is taken by the consumer's flops on the same edge.
  assign o_pair.first  = r_neg;
  assign o_pair.second = data_p;

endmodule

// File: rtl/dphy_lane_receiver.sv
// Single-lane HS receiver: hunts for the 0xB8 sync after a zero leader, then emits one byte per 4 cycles.
module dphy_lane_receiver
  import dphy_pkg::*;
#(
  parameter int ZERO_ACCUMULATOR_WIDTH = 2
) (
  input  logic       clock_p,
  input  logic       reset,
  input  logic       data_p,
  output logic [7:0] data,
  output logic       enable
);

  localparam int ZERO_TARGET = ZERO_ACCUMULATOR_WIDTH + 3;
  localparam int ACC_W = $clog2(ZERO_TARGET + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(ZERO_TARGET);

  // enable is a pure one-cycle strobe with no backpressure: data is valid in exactly the enable cycle
  // and holds afterwards until the next strobe.
  lane_state_t      r_state;
  logic [8:2]       r_window;
  logic [3:0]       r_zflag;
  logic [ACC_W-1:0] r_zero_acc;
  logic [1:0]       r_count;
  logic             r_phase;
  logic [7:0]       r_data;
  logic             r_enable;

  bit_pair_t        w_pair;
  logic [8:0]       w_window;
  logic [3:0]       w_zflag_next;
  logic [ACC_W-1:0] w_acc_mid;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_sync0;
  logic             w_sync1;
  logic [7:0]       w_byte;

  dphy_ddr_capture u_capture (
    .clock_p (clock_p),
    .reset   (reset),
    .data_p  (data_p),
    .o_pair  (w_pair)
  );

  // Window bit 8 is the newest (rising-edge) bit; bits [8:7] are live, [6:0] were registered earlier.
  assign w_window = {w_pair.second, w_pair.first, r_window};

  // A flag per bit records whether a full zero run preceded it; only the pattern's first 1 needs it.
  always_comb begin
    w_acc_mid  = (r_zero_acc == ACC_MAX) ? r_zero_acc : r_zero_acc + ACC_W'(1);
    if (w_pair.first) w_acc_mid = '0;
    w_acc_next = (w_acc_mid == ACC_MAX) ? w_acc_mid : w_acc_mid + ACC_W'(1);
    if (w_pair.second) w_acc_next = '0;
    w_zflag_next = {(w_acc_mid == ACC_MAX), (r_zero_acc == ACC_MAX), r_zflag[3:2]};
  end

  // Flag bit 1 lines up with window bit 4 this cycle, flag bit 0 with window bit 3.
  assign w_sync0 = (w_window[8:1] == SYNC_BYTE) && r_zflag[1];
  assign w_sync1 = (w_window[7:0] == SYNC_BYTE) && r_zflag[0];
  assign w_byte  = r_phase ? w_window[7:0] : w_window[8:1];

  always_ff @(posedge clock_p) begin
    if (reset) begin
      r_state    <= HUNT;
      r_window   <= '0;
      r_zflag    <= '0;
      r_zero_acc <= '0;
      r_count    <= 2'd0;
      r_phase    <= 1'b0;
      r_data     <= 8'h00;
      r_enable   <= 1'b0;
    end else begin
      r_window <= w_window[8:2];
      r_zflag  <= w_zflag_next;
      r_enable <= 1'b0;
      case (r_state)
        HUNT: begin
          r_zero_acc <= w_acc_next;
          if (w_sync0 || w_sync1) begin
            r_state <= RECEIVE;
            r_phase <= ~w_sync0;
            r_count <= 2'd0;
          end
        end
        RECEIVE: begin
          r_count <= r_count + 2'd1;
          if (r_count == 2'd3) begin
            r_data   <= w_byte;
            r_enable <= 1'b1;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign data   = r_data;
  assign enable = r_enable;

endmodule

// File: tb/tb_dphy_lane_receiver.sv
// Bench for dphy_lane_receiver and csi_header_ecc: serial stimulus with a byte/cycle scoreboard.
module tb_dphy_lane_receiver;

  logic        clock_p = 1'b0;
  logic        reset   = 1'b1;
  logic        data_p  = 1'b0;
  logic [7:0]  data;
  logic        enable;
  logic [23:0] ecc_hdr = 24'h0;
  logic [7:0]  ecc_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_en    = 0;

  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [7:0] m_exp;
  int         m_cyc;
  logic [7:0] ecc_tab [24];

  dphy_lane_receiver #(.ZERO_ACCUMULATOR_WIDTH(2)) dut (
    .clock_p (clock_p),
    .reset   (reset),
    .data_p  (data_p),
    .data    (data),
    .enable  (enable)
  );

  csi_header_ecc u_ecc (
    .data (ecc_hdr),
    .ecc  (ecc_out)
  );

  // clock / reset
  always #5 clock_p = ~clock_p;
  always @(posedge clock_p) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // scoreboard: every enable must match the next expected byte and the cycle it was due
  always begin
    @(posedge clock_p);
    #1;
    if (enable === 1'b1) begin
      n_en++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_enable: got data=%h at cycle %0d, expected no byte", data, cyc);
      end else begin
        m_exp = exp_q.pop_front();
        m_cyc = exp_cyc_q.pop_front();
        if (data !== m_exp) begin
          n_fail++;
          $display("FAIL byte_data: got %h, expected %h", data, m_exp);
        end
        n_tests++;
        if (cyc != m_cyc) begin
          n_fail++;
          $display("FAIL byte_latency: enable at cycle %0d, expected cycle %0d", cyc, m_cyc);
        end
      end
    end
  end

  // driver tasks
  task automatic send_bit(input logic b);
    data_p = b;
    @(posedge clock_p or negedge clock_p);
    #2;
  endtask

  task automatic send_run(input logic b, input int n);
    for (int i = 0; i < n; i++) send_bit(b);
  endtask

  // The last bit of a byte always lands before the next rising edge, where enable must rise.
  task automatic send_byte(input logic [7:0] v, input bit expect_out);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && expect_out) begin
        exp_q.push_back(v);
        exp_cyc_q.push_back(cyc + 1);
      end
      send_bit(v[i]);
    end
  endtask

  task automatic start_stream();
    @(posedge clock_p);
    #2;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clock_p);
      #2;
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes still pending, expected 0", name, exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic rearm();
    data_p = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clock_p);
    #2;
    reset = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    reset  = 1'b1;
    data_p = 1'bx;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock_p);
      #2;
      n_tests++;
      if (enable !== 1'b0 || data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_state: enable=%b data=%h, expected 0 / 00", enable, data);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock_p);
      #2;
      n_tests++;
      if (enable !== 1'b0 || data !== 8'h00) begin
        n_fail++;
        $display("FAIL x_lane_hunt: enable=%b data=%h, expected 0 / 00", enable, data);
      end
    end
  endtask

  task automatic test_phase0();
    rearm();
    start_stream();
    send_run(1'b1, 3);
    send_run(1'b0, 5);
    send_byte(8'hB8, 1'b0);
    send_byte(8'h2B, 1'b1);
    send_byte(8'h12, 1'b1);
    drain("phase0");
  endtask

  task automatic test_phase1();
    rearm();
    start_stream();
    send_run(1'b1, 4);
    send_run(1'b0, 5);
    send_byte(8'hB8, 1'b0);
    send_byte(8'h2B, 1'b1);
    send_byte(8'h12, 1'b1);
    drain("phase1");
  endtask

  task automatic test_short_leader();
    int en0;
    rearm();
    start_stream();
    en0 = n_en;
    send_run(1'b1, 4);
    send_run(1'b0, 1);
    send_byte(8'hB8, 1'b0);
    send_run(1'b1, 10);
    n_tests++;
    if (n_en != en0) begin
      n_fail++;
      $display("FAIL short_leader_lock: %0d enables seen, expected 0", n_en - en0);
    end
    send_run(1'b0, 5);
    send_byte(8'hB8, 1'b0);
    send_byte(8'hA5, 1'b1);
    drain("short_leader");
  endtask

  task automatic test_payload_sync();
    rearm();
    start_stream();
    send_run(1'b1, 3);
    send_run(1'b0, 5);
    send_byte(8'hB8, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'hB8, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h5C, 1'b1);
    drain("payload_sync");
  endtask

  task automatic test_reset_on_byte();
    logic [7:0] v;
    rearm();
    start_stream();
    send_run(1'b1, 3);
    send_run(1'b0, 5);
    send_byte(8'hB8, 1'b0);
    send_byte(8'h5A, 1'b1);
    v = 8'hC3;
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    reset = 1'b1;
    send_bit(v[7]);
    n_tests++;
    if (enable !== 1'b0 || data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_on_byte: enable=%b data=%h, expected 0 / 00", enable, data);
    end
    @(posedge clock_p);
    #2;
    n_tests++;
    if (enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: enable=%b, expected 0", enable);
    end
    reset = 1'b0;
    send_run(1'b1, 4);
    send_run(1'b0, 5);
    send_byte(8'hB8, 1'b0);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h7E, 1'b1);
    drain("relock");
  endtask

  task automatic test_ecc();
    logic [7:0] exp_ecc;
    ecc_tab = '{8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
                8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
                8'h31, 8'h32, 8'h34, 8'h38, 8'h1F, 8'h2F, 8'h37, 8'h3B};
    ecc_hdr = 24'h000000;
    #1;
    n_tests++;
    if (ecc_out !== 8'h00) begin
      n_fail++;
      $display("FAIL ecc_zero: got %h, expected 00", ecc_out);
    end
    for (int i = 0; i < 24; i++) begin
      ecc_hdr = 24'h000001 << i;
      #1;
      n_tests++;
      if (ecc_out !== ecc_tab[i]) begin
        n_fail++;
        $display("FAIL ecc_bit%0d: got %h, expected %h", i, ecc_out, ecc_tab[i]);
      end
    end
    for (int k = 0; k < 16; k++) begin
      ecc_hdr = 24'($urandom_range(0, 32'h00FF_FFFF));
      exp_ecc = 8'h00;
      for (int j = 0; j < 24; j++) if (ecc_hdr[j]) exp_ecc = exp_ecc ^ ecc_tab[j];
      #1;
      n_tests++;
      if (ecc_out !== exp_ecc || ecc_out[7:6] !== 2'b00) begin
        n_fail++;
        $display("FAIL ecc_random: hdr=%h got %h, expected %h", ecc_hdr, ecc_out, exp_ecc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_phase0();
    test_phase1();
    test_short_leader();
    test_payload_sync();
    test_reset_on_byte();
    rearm();
    test_ecc();
    repeat (4) @(posedge clock_p);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
